// File: rtl/uart_fifo_ctrl_if.sv
// Signal bundle between the UART FIFO controller and its register file, receiver and FIFOs.
// The slave modport is the controller; the master modport is everything around it.
interface uart_fifo_ctrl_if;
  logic       fcr_we;
  logic [7:0] fcr_wdata;
  logic       rbr_rd;
  logic       lsr_rd;
  logic       rx_char_valid;
  logic       char_tick;
  logic       rx_fifo_empty;
  logic       rx_fifo_full;
  logic       rx_fifo_thre;
  logic       fifo_en;
  logic [3:0] rx_threshold;
  logic       rx_fifo_push;
  logic       rx_fifo_pop;
  logic       rx_fifo_clr;
  logic       tx_fifo_clr;
  logic       overrun;
  logic       rx_data_irq;
  logic       rx_timeout_irq;

  modport master (
    output fcr_we, fcr_wdata, rbr_rd, lsr_rd, rx_char_valid, char_tick,
           rx_fifo_empty, rx_fifo_full, rx_fifo_thre,
    input  fifo_en, rx_threshold, rx_fifo_push, rx_fifo_pop, rx_fifo_clr,
           tx_fifo_clr, overrun, rx_data_irq, rx_timeout_irq
  );

  modport slave (
    input  fcr_we, fcr_wdata, rbr_rd, lsr_rd, rx_char_valid, char_tick,
           rx_fifo_empty, rx_fifo_full, rx_fifo_thre,
    output fifo_en, rx_threshold, rx_fifo_push, rx_fifo_pop, rx_fifo_clr,
           tx_fifo_clr, overrun, rx_data_irq, rx_timeout_irq
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// UART 16550 FIFO control: FCR decode, clear sequencing, RX push/pop gating,
// overrun flag, data-available and character-timeout interrupts.
module uart_fifo_ctrl #(
  parameter int CLR_CYCLES = 2,
  parameter int TO_CHARS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_fifo_ctrl_if.slave   bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state;
  logic [3:0] clr_cnt;
  logic       fifo_en_q;
  logic [3:0] thr_q;
  logic       rx_clr_q;
  logic       tx_clr_q;
  logic       ovr_q;
  logic       to_irq_q;
  logic [2:0] to_cnt;
  logic [2:0] to_cnt_next;

  logic       en_bit;
  logic       toggle;
  logic       req_rx;
  logic       req_tx;
  logic       is_idle;
  logic       push_ok;
  logic       push;
  logic       pop;
  logic       ovr_set;
  logic       to_clear;
  logic       unused_fcr_bits;

  // Bits 5:3 (DMA mode and reserved) have no effect on this block.
  assign unused_fcr_bits = ^bus.fcr_wdata[5:3];

  function automatic logic [3:0] trig_level(input logic [1:0] code);
    case (code)
      2'b00:   trig_level = 4'd1;
      2'b01:   trig_level = 4'd4;
      2'b10:   trig_level = 4'd8;
      default: trig_level = 4'd14;
    endcase
  endfunction

  // Changing the enable flushes both FIFOs; explicit clears need enable set in the same write.
  assign en_bit  = bus.fcr_wdata[0];
  assign toggle  = bus.fcr_we & (en_bit != fifo_en_q);
  assign req_rx  = (bus.fcr_we & en_bit & bus.fcr_wdata[1]) | toggle;
  assign req_tx  = (bus.fcr_we & en_bit & bus.fcr_wdata[2]) | toggle;

  // Non-FIFO mode behaves as a single holding register: accept only when empty.
  assign is_idle = (state == IDLE);
  assign push_ok = fifo_en_q ? ~bus.rx_fifo_full : bus.rx_fifo_empty;
  assign push    = bus.rx_char_valid & is_idle & push_ok;
  assign pop     = bus.rbr_rd & is_idle & ~bus.rx_fifo_empty;
  assign ovr_set = bus.rx_char_valid & is_idle & ~push_ok;

  assign to_clear = push | pop | bus.rx_fifo_empty | ~is_idle | ~fifo_en_q;

  always_comb begin
    to_cnt_next = to_cnt;
    if (to_clear)
      to_cnt_next = 3'd0;
    else if (bus.char_tick && (to_cnt != 3'(TO_CHARS)))
      to_cnt_next = to_cnt + 3'd1;
  end

  // FCR register and clear sequencer; a clear request during CLEAR restarts the hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clr_cnt   <= 4'd0;
      fifo_en_q <= 1'b0;
      thr_q     <= 4'd1;
      rx_clr_q  <= 1'b0;
      tx_clr_q  <= 1'b0;
    end else begin
      if (bus.fcr_we) begin
        fifo_en_q <= en_bit;
        thr_q     <= trig_level(bus.fcr_wdata[7:6]);
      end
      case (state)
        IDLE: begin
          if (req_rx || req_tx) begin
            state    <= CLEAR;
            clr_cnt  <= 4'(CLR_CYCLES - 1);
            rx_clr_q <= req_rx;
            tx_clr_q <= req_tx;
          end
        end
        CLEAR: begin
          if (req_rx || req_tx) begin
            clr_cnt  <= 4'(CLR_CYCLES - 1);
            rx_clr_q <= rx_clr_q | req_rx;
            tx_clr_q <= tx_clr_q | req_tx;
          end else if (clr_cnt == 4'd0) begin
            state    <= IDLE;
            rx_clr_q <= 1'b0;
            tx_clr_q <= 1'b0;
          end else begin
            clr_cnt  <= clr_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overrun (set beats the LSR read) and the RX inactivity timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q    <= 1'b0;
      to_cnt   <= 3'd0;
      to_irq_q <= 1'b0;
    end else begin
      if (ovr_set)
        ovr_q <= 1'b1;
      else if (bus.lsr_rd)
        ovr_q <= 1'b0;
      to_cnt   <= to_cnt_next;
      to_irq_q <= (to_cnt_next == 3'(TO_CHARS));
    end
  end

  assign bus.fifo_en        = fifo_en_q;
  assign bus.rx_threshold   = thr_q;
  assign bus.rx_fifo_push   = push;
  assign bus.rx_fifo_pop    = pop;
  assign bus.rx_fifo_clr    = rx_clr_q;
  assign bus.tx_fifo_clr    = tx_clr_q;
  assign bus.overrun        = ovr_q;
  assign bus.rx_data_irq    = fifo_en_q ? bus.rx_fifo_thre : ~bus.rx_fifo_empty;
  assign bus.rx_timeout_irq = to_irq_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them independently.
module tb_uart_fifo_ctrl;

  typedef enum int {S_FIFO_EN, S_THR, S_PUSH, S_POP, S_RXCLR, S_TXCLR,
                    S_OVR, S_DIRQ, S_TOIRQ} sig_e;

  typedef struct {
    int         cyc;
    sig_e       sig;
    logic [3:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  logic lv_empty;
  logic lv_full;
  logic lv_thre;
  exp_t exp_q[$];

  uart_fifo_ctrl_if bus();

  uart_fifo_ctrl #(.CLR_CYCLES(2), .TO_CHARS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] get_sig(input sig_e s);
    case (s)
      S_FIFO_EN: get_sig = {3'b0, bus.fifo_en};
      S_THR:     get_sig = bus.rx_threshold;
      S_PUSH:    get_sig = {3'b0, bus.rx_fifo_push};
      S_POP:     get_sig = {3'b0, bus.rx_fifo_pop};
      S_RXCLR:   get_sig = {3'b0, bus.rx_fifo_clr};
      S_TXCLR:   get_sig = {3'b0, bus.tx_fifo_clr};
      S_OVR:     get_sig = {3'b0, bus.overrun};
      S_DIRQ:    get_sig = {3'b0, bus.rx_data_irq};
      default:   get_sig = {3'b0, bus.rx_timeout_irq};
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [3:0] act;
    act = get_sig(e.sig);
    n_tests++;
    if (act !== e.val) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", e.sig.name(), e.cyc, act, e.val);
    end
  endtask

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        checkOutput(exp_q[i]);
        exp_q.delete(i);
      end
    end
  end

  task automatic expectAt(input int off, input sig_e s, input int v);
    exp_t e;
    e.cyc = cyc + off;
    e.sig = s;
    e.val = 4'(v);
    exp_q.push_back(e);
  endtask

  // One call drives one clock cycle of inputs, applied just after the rising edge.
  task automatic applyStimulus(input logic we, input logic [7:0] wdata, input logic rbr,
                               input logic lsr, input logic rxv, input logic tick);
    @(posedge clk);
    #1;
    bus.fcr_we        = we;
    bus.fcr_wdata     = wdata;
    bus.rbr_rd        = rbr;
    bus.lsr_rd        = lsr;
    bus.rx_char_valid = rxv;
    bus.char_tick     = tick;
    bus.rx_fifo_empty = lv_empty;
    bus.rx_fifo_full  = lv_full;
    bus.rx_fifo_thre  = lv_thre;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc = 0; n_tests = 0; n_fail = 0;
    lv_empty = 1'b1; lv_full = 1'b0; lv_thre = 1'b0;
    bus.fcr_we = 1'b0; bus.fcr_wdata = 8'h00; bus.rbr_rd = 1'b0; bus.lsr_rd = 1'b0;
    bus.rx_char_valid = 1'b0; bus.char_tick = 1'b0;
    bus.rx_fifo_empty = 1'b1; bus.rx_fifo_full = 1'b0; bus.rx_fifo_thre = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset values
    idle(1);
    expectAt(0, S_FIFO_EN, 0); expectAt(0, S_THR, 1); expectAt(0, S_RXCLR, 0);
    expectAt(0, S_TXCLR, 0); expectAt(0, S_OVR, 0); expectAt(0, S_DIRQ, 0);
    expectAt(0, S_TOIRQ, 0); expectAt(0, S_PUSH, 0); expectAt(0, S_POP, 0);

    // Enable with trigger 14: enable toggles so both FIFOs clear for two cycles
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
    expectAt(1, S_FIFO_EN, 1); expectAt(1, S_THR, 14);
    expectAt(1, S_RXCLR, 1); expectAt(1, S_TXCLR, 1);
    expectAt(2, S_RXCLR, 1); expectAt(2, S_TXCLR, 1);
    expectAt(3, S_RXCLR, 0); expectAt(3, S_TXCLR, 0);
    idle(4);

    // FIFO full: push refused, overrun, LSR clear, set beats clear
    lv_empty = 1'b0; lv_full = 1'b1; lv_thre = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    expectAt(0, S_PUSH, 0); expectAt(0, S_DIRQ, 1); expectAt(1, S_OVR, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expectAt(0, S_OVR, 1); expectAt(1, S_OVR, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    expectAt(1, S_OVR, 1);
    lv_full = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expectAt(1, S_OVR, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    expectAt(0, S_PUSH, 1); expectAt(1, S_OVR, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    expectAt(0, S_POP, 1);
    lv_thre = 1'b0;
    idle(1);
    expectAt(0, S_DIRQ, 0);

    // RX-only clear; receive and read during CLEAR are discarded
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    expectAt(1, S_RXCLR, 1); expectAt(1, S_TXCLR, 0);
    expectAt(1, S_FIFO_EN, 1); expectAt(1, S_THR, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    expectAt(0, S_PUSH, 0); expectAt(1, S_OVR, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    expectAt(0, S_POP, 0); expectAt(0, S_RXCLR, 1);
    expectAt(1, S_RXCLR, 0); expectAt(1, S_TXCLR, 0);
    idle(2);

    // Character timeout after four idle character times, saturation, cleared by pop
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expectAt(1, S_TOIRQ, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expectAt(0, S_TOIRQ, 0); expectAt(1, S_TOIRQ, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expectAt(1, S_TOIRQ, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    expectAt(0, S_POP, 1); expectAt(0, S_TOIRQ, 1); expectAt(1, S_TOIRQ, 0);
    idle(1);

    // Disable FIFOs: both clear, then single-holding-register behaviour
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expectAt(1, S_FIFO_EN, 0); expectAt(1, S_RXCLR, 1); expectAt(1, S_TXCLR, 1);
    expectAt(3, S_RXCLR, 0); expectAt(3, S_TXCLR, 0);
    idle(3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    expectAt(0, S_PUSH, 0); expectAt(0, S_DIRQ, 1); expectAt(1, S_OVR, 1);
    lv_empty = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expectAt(0, S_DIRQ, 0); expectAt(1, S_OVR, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    expectAt(0, S_PUSH, 1); expectAt(1, S_OVR, 0);

    // Reset in the first CLEAR cycle
    lv_empty = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    expectAt(1, S_OVR, 1);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    #2 rst = 1'b1;
    expectAt(0, S_FIFO_EN, 0); expectAt(0, S_THR, 1); expectAt(0, S_RXCLR, 0);
    expectAt(0, S_TXCLR, 0); expectAt(0, S_OVR, 0); expectAt(0, S_TOIRQ, 0);
    idle(2);
    rst = 1'b0;
    expectAt(0, S_RXCLR, 0); expectAt(0, S_TXCLR, 0);
    expectAt(1, S_RXCLR, 0); expectAt(1, S_TXCLR, 0); expectAt(1, S_FIFO_EN, 0);
    expectAt(2, S_RXCLR, 0); expectAt(2, S_TXCLR, 0);
    idle(3);
    @(negedge clk);
    #1;

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d unchecked entries, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
